// File: rtl/regfile_write_arbiter_if.sv
// Write-back bus between the execute/memory stages and the register-file write arbiter.
interface regfile_write_arbiter_if;
  logic        AValid;
  logic        AReady;
  logic [4:0]  AAddr;
  logic [31:0] AData;
  logic        MValid;
  logic        MReady;
  logic [4:0]  MAddr;
  logic [31:0] MData;
  logic [31:0] En;
  logic [31:0] DataIn;
  logic [31:0] Pending;
  logic        Idle;

  modport master (
    output AValid, AAddr, AData, MValid, MAddr, MData,
    input  AReady, MReady, En, DataIn, Pending, Idle
  );

  modport slave (
    input  AValid, AAddr, AData, MValid, MAddr, MData,
    output AReady, MReady, En, DataIn, Pending, Idle
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU (A) and load (M) requesters.
// Define REGFILE_WRITE_ARB_RR_EN for round-robin arbitration; default is fixed M-over-A priority.
module regfile_write_arbiter #(
  parameter int unsigned DEPTH = 2
) (
  input logic                    Clock,
  input logic                    Reset,
  regfile_write_arbiter_if.slave bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  // Side index: 0 = ALU (A), 1 = load (M)
  logic [4:0]    r_addr [2][DEPTH];
  logic [31:0]   r_data [2][DEPTH];
  logic [CW-1:0] r_cnt  [2];
  logic [31:0]   r_en;
  logic [31:0]   r_data_out;

  logic [4:0]    w_addr_n [2][DEPTH];
  logic [31:0]   w_data_n [2][DEPTH];
  logic [CW-1:0] w_cnt_n  [2];
  logic [CW-1:0] w_wr_idx [2];
  logic          w_vld    [2];
  logic [4:0]    w_in_addr[2];
  logic [31:0]   w_in_data[2];
  logic          w_ready  [2];
  logic          w_push   [2];
  logic          w_pop    [2];
  logic          w_ne     [2];
  logic          w_gnt_vld;
  logic          w_gnt_side;
  logic [4:0]    w_gnt_addr;
  logic [31:0]   w_gnt_data;
  logic [31:0]   w_pending;

  function automatic logic [31:0] f_dec(input logic [4:0] a);
    f_dec = '0;
    if (a != '0) f_dec[a] = 1'b1;
  endfunction

  assign w_vld[0]     = bus.AValid;
  assign w_vld[1]     = bus.MValid;
  assign w_in_addr[0] = bus.AAddr;
  assign w_in_addr[1] = bus.MAddr;
  assign w_in_data[0] = bus.AData;
  assign w_in_data[1] = bus.MData;

  always_comb begin
    for (int unsigned s = 0; s < 2; s++) begin
      w_ne[s]    = (r_cnt[s] != '0);
      w_ready[s] = (r_cnt[s] != CW'(DEPTH));
      w_push[s]  = w_vld[s] && w_ready[s];
    end
  end

  assign w_gnt_vld = w_ne[0] || w_ne[1];

`ifdef REGFILE_WRITE_ARB_RR_EN
  logic r_prio;  // 0 = A, 1 = M; only moves on a contested grant

  assign w_gnt_side = (w_ne[0] && w_ne[1]) ? r_prio : w_ne[1];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_prio <= 1'b0;
    end else if (w_ne[0] && w_ne[1]) begin
      r_prio <= ~r_prio;
    end
  end
`else
  assign w_gnt_side = w_ne[1];
`endif

  always_comb begin
    w_pop[0]   = w_gnt_vld && !w_gnt_side;
    w_pop[1]   = w_gnt_vld && w_gnt_side;
    w_gnt_addr = w_gnt_side ? r_addr[1][0] : r_addr[0][0];
    w_gnt_data = w_gnt_side ? r_data[1][0] : r_data[0][0];
  end

  // Head is always slot 0: a pop shifts down, and a same-edge push lands just behind the survivors.
  always_comb begin
    for (int unsigned s = 0; s < 2; s++) begin
      w_cnt_n[s]  = r_cnt[s] - CW'(w_pop[s]) + CW'(w_push[s]);
      w_wr_idx[s] = r_cnt[s] - CW'(w_pop[s]);
      for (int unsigned i = 0; i < DEPTH; i++) begin
        w_addr_n[s][i] = r_addr[s][i];
        w_data_n[s][i] = r_data[s][i];
        if (w_pop[s] && (i + 1 < DEPTH)) begin
          w_addr_n[s][i] = r_addr[s][i+1];
          w_data_n[s][i] = r_data[s][i+1];
        end
        if (w_push[s] && (w_wr_idx[s] == CW'(i))) begin
          w_addr_n[s][i] = w_in_addr[s];
          w_data_n[s][i] = w_in_data[s];
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_en       <= '0;
      r_data_out <= '0;
      for (int unsigned s = 0; s < 2; s++) begin
        r_cnt[s] <= '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
          r_addr[s][i] <= '0;
          r_data[s][i] <= '0;
        end
      end
    end else begin
      for (int unsigned s = 0; s < 2; s++) begin
        r_cnt[s] <= w_cnt_n[s];
        for (int unsigned i = 0; i < DEPTH; i++) begin
          r_addr[s][i] <= w_addr_n[s][i];
          r_data[s][i] <= w_data_n[s][i];
        end
      end
      r_en <= w_gnt_vld ? f_dec(w_gnt_addr) : '0;
      if (w_gnt_vld) r_data_out <= w_gnt_data;
    end
  end

  always_comb begin
    w_pending = r_en;
    for (int unsigned s = 0; s < 2; s++) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (CW'(i) < r_cnt[s]) w_pending = w_pending | f_dec(r_addr[s][i]);
      end
    end
  end

  assign bus.AReady  = w_ready[0];
  assign bus.MReady  = w_ready[1];
  assign bus.En      = r_en;
  assign bus.DataIn  = r_data_out;
  assign bus.Pending = w_pending;
  assign bus.Idle    = !w_ne[0] && !w_ne[1] && (r_en == '0);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized scoreboard bench for regfile_write_arbiter against a queue-based reference model.
module tb_regfile_write_arbiter;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter #(.DEPTH(2)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        qa[$];
  ent_t        qm[$];
  logic [63:0] sb[$];
  logic [31:0] m_en  = '0;
  bit          m_ptr = 1'b0;

  int checks   = 0;
  int failures = 0;

`ifdef REGFILE_WRITE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  function automatic logic [31:0] dec(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : (32'd1 << a);
  endfunction

  function automatic logic [31:0] exp_pending();
    logic [31:0] p;
    p = m_en;
    foreach (qa[i]) p = p | dec(qa[i].a);
    foreach (qm[i]) p = p | dec(qm[i].a);
    return p;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every write reaching the register file must match the oldest expected write.
  always @(negedge Clock) begin
    if (bus.En !== 32'd0) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_write actual=%h expected=none at %0t", bus.En, $time);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("write_en", bus.En, e[63:32]);
        chk("write_data", bus.DataIn, e[31:0]);
      end
    end
  end

  task automatic cycle(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                       input bit mv, input logic [4:0] ma, input logic [31:0] md,
                       input bit rst);
    bit   acc_a, acc_m, g_vld, g_m;
    ent_t g, na, nm;
    @(negedge Clock);
    chk("AReady", 32'(bus.AReady), 32'(qa.size() < 2));
    chk("MReady", 32'(bus.MReady), 32'(qm.size() < 2));
    chk("Pending", bus.Pending, exp_pending());
    chk("Idle", 32'(bus.Idle), 32'(qa.size() == 0 && qm.size() == 0 && m_en == 0));
    bus.AValid = av; bus.AAddr = aa; bus.AData = ad;
    bus.MValid = mv; bus.MAddr = ma; bus.MData = md;
    Reset = rst;
    @(posedge Clock);
    if (rst) begin
      qa.delete(); qm.delete(); sb.delete();
      m_en = '0; m_ptr = 1'b0;
      return;
    end
    acc_a = av && (qa.size() < 2);
    acc_m = mv && (qm.size() < 2);
    g_vld = (qa.size() > 0) || (qm.size() > 0);
    if (qa.size() > 0 && qm.size() > 0) begin
      if (RR) begin
        g_m   = m_ptr;
        m_ptr = !m_ptr;
      end else begin
        g_m = 1'b1;
      end
    end else begin
      g_m = (qm.size() > 0);
    end
    if (g_vld) g = g_m ? qm.pop_front() : qa.pop_front();
    na.a = aa; na.d = ad;
    nm.a = ma; nm.d = md;
    if (acc_a) qa.push_back(na);
    if (acc_m) qm.push_back(nm);
    m_en = g_vld ? dec(g.a) : 32'd0;
    if (m_en != 0) sb.push_back({m_en, g.d});
  endtask

  task automatic idle();
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  initial begin
    bus.AValid = 1'b0; bus.AAddr = '0; bus.AData = '0;
    bus.MValid = 1'b0; bus.MAddr = '0; bus.MData = '0;

    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    idle();

    // Single uncontested write to r5
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0);
    #1 chk("single_pend_e1", bus.Pending, 32'h20);
    chk("single_en_e1", bus.En, 32'h0);
    idle();
    #1 chk("single_en_e2", bus.En, 32'h20);
    chk("single_data_e2", bus.DataIn, 32'hDEADBEEF);
    chk("single_pend_e2", bus.Pending, 32'h20);
    idle();
    #1 chk("single_pend_e3", bus.Pending, 32'h0);
    chk("single_en_e3", bus.En, 32'h0);

    // Address zero consumes a grant but never writes
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h12345678, 1'b0);
    #1 chk("zero_pend", bus.Pending, 32'h0);
    chk("zero_mready", 32'(bus.MReady), 32'd1);
    idle();
    #1 chk("zero_en", bus.En, 32'h0);
    idle();

    // Contention from a freshly reset priority pointer
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    cycle(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0);
    idle();
    #1 chk("contend_first", bus.En, RR ? 32'h2 : 32'h4);
    idle();
    #1 chk("contend_second", bus.En, RR ? 32'h4 : 32'h2);
    cycle(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b0);
    idle();
    #1 chk("contend2_first", bus.En, RR ? 32'h10 : 32'h10);
    idle();
    #1 chk("contend2_second", bus.En, 32'h8);
    idle();

    // Back-pressure: both sides streaming
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 5'(10 + i), 32'hA000 + 32'(i), 1'b1, 5'(20 + i), 32'hB000 + 32'(i), 1'b0);
    if (!RR) begin
      #1 chk("bp_aready_low", 32'(bus.AReady), 32'd0);
    end
    for (int i = 0; i < 6; i++) idle();

    // Reset with both FIFOs loaded
    cycle(1'b1, 5'd7, 32'h77, 1'b1, 5'd8, 32'h88, 1'b0);
    cycle(1'b1, 5'd9, 32'h99, 1'b1, 5'd6, 32'h66, 1'b0);
    cycle(1'b1, 5'd11, 32'hBB, 1'b1, 5'd12, 32'hCC, 1'b1);
    #1 chk("rst_en", bus.En, 32'h0);
    chk("rst_pend", bus.Pending, 32'h0);
    chk("rst_ready", {30'd0, bus.AReady, bus.MReady}, 32'h3);
    chk("rst_idle", 32'(bus.Idle), 32'd1);
    for (int i = 0; i < 3; i++) idle();

    // Randomized traffic with varying load and occasional reset
    for (int blk = 0; blk < 10; blk++) begin
      int unsigned pa, pm;
      pa = $urandom_range(10, 100);
      pm = $urandom_range(10, 100);
      for (int i = 0; i < 200; i++) begin
        logic [4:0] ra, rm;
        ra = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        rm = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        cycle($urandom_range(0, 99) < pa, ra, $urandom,
              $urandom_range(0, 99) < pm, rm, $urandom,
              $urandom_range(0, 99) == 0);
      end
    end

    for (int i = 0; i < 8; i++) idle();
    @(negedge Clock);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("final_idle", 32'(bus.Idle), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
